// File: rtl/laser16_pkg.sv
// Shared types and constants for the single-shot laser timer.
package laser16_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    localparam int LASER_ON_CYCLES = 16;

endpackage

// File: rtl/laser16_count.sv
// Loadable down-counter with a terminal-count flag.
module laser16_count #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at zero so a stray enable cannot wrap the count.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/laser16_ctrl.sv
// Single-shot laser timer: one B pulse holds XL high for ON_CYCLES clocks.
module laser16_ctrl
    import laser16_pkg::*;
#(
    parameter int ON_CYCLES = LASER_ON_CYCLES,
    parameter int CNT_W     = $clog2(ON_CYCLES)
) (
    input  logic CLK,
    input  logic Reset,
    input  logic B,
    output logic XL
);

    localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(ON_CYCLES - 1);

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_en;
    logic   w_tc;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= OFF;
        end else begin
            r_state <= w_next;
        end
    end

    // B only matters in OFF; ON runs to terminal count untouched.
    always_comb begin
        w_next = OFF;
        w_load = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            OFF: begin
                if (B) begin
                    w_next = ON;
                    w_load = 1'b1;
                end
            end
            ON: begin
                if (!w_tc) begin
                    w_next = ON;
                    w_en   = 1'b1;
                end
            end
            default: w_next = OFF;
        endcase
    end

    laser16_count #(
        .CNT_W(CNT_W)
    ) u_count (
        .i_clk     (CLK),
        .i_clear   (Reset),
        .i_load    (w_load),
        .i_load_val(LP_LOAD),
        .i_en      (w_en),
        .o_tc      (w_tc)
    );

    assign XL = (r_state == ON);

endmodule

// File: tb/tb_laser16_ctrl.sv
// Self-checking bench for laser16_ctrl: directed vector table plus random run.
module tb_laser16_ctrl;

    localparam int ONC = 16;

    typedef struct {
        logic  rst;
        logic  b;
        logic  exp_xl;
        string name;
    } vec_t;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    logic B     = 1'b0;
    logic XL;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   left   = 0;
    vec_t vq[$];

    laser16_ctrl #(.ON_CYCLES(ONC)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .B    (B),
        .XL   (XL)
    );

    always #10 CLK = ~CLK;

    task automatic add(input logic r, input logic b, input logic e,
                       input int n, input string nm);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst    = r;
            v.b      = b;
            v.exp_xl = e;
            v.name   = nm;
            vq.push_back(v);
        end
    endtask

    // Behavioural model: cycles of laser time still owed.
    task automatic model_edge(input logic r, input logic b);
        if (r) left = 0;
        else if (left > 0) left--;
        else if (b) left = ONC;
    endtask

    task automatic step(input logic r, input logic b, input logic e,
                        input bit use_tbl, input string nm);
        logic want;
        @(negedge CLK);
        Reset = r;
        B     = b;
        @(posedge CLK);
        model_edge(r, b);
        cyc++;
        #1;
        want = use_tbl ? e : (left > 0);
        checks++;
        if (XL !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: XL=%b expected %b", nm, cyc, XL, want);
        end
    endtask

    initial begin
        // 1: reset and idle
        add(1, 0, 0, 3, "reset");
        add(0, 0, 0, 9, "idle_after_reset");
        // 2: single press
        add(0, 1, 1, 1, "single_rise");
        add(0, 0, 1, ONC - 1, "single_on");
        add(0, 0, 0, 1, "single_fall");
        add(0, 0, 0, 10, "single_stay_off");
        // 3: press during ON is ignored
        add(0, 1, 1, 1, "retrig_rise");
        add(0, 0, 1, 3, "retrig_on_a");
        add(0, 1, 1, 1, "retrig_press_on");
        add(0, 0, 1, ONC - 5, "retrig_on_b");
        add(0, 0, 0, 5, "retrig_fall");
        // 4: reset mid-pulse
        add(0, 1, 1, 1, "abort_rise");
        add(0, 0, 1, 6, "abort_on");
        add(1, 0, 0, 1, "abort_reset");
        add(0, 0, 0, 5, "abort_stay_off");
        // 5: back-to-back with one-cycle gap
        add(0, 1, 1, 1, "b2b_rise1");
        add(0, 0, 1, ONC - 1, "b2b_on1");
        add(0, 0, 0, 1, "b2b_fall1");
        add(0, 1, 1, 1, "b2b_rise2");
        add(0, 0, 1, ONC - 1, "b2b_on2");
        add(0, 0, 0, 1, "b2b_fall2");
        // B at the falling edge is sampled in ON and dropped
        add(0, 1, 1, 1, "edge_rise");
        add(0, 0, 1, ONC - 1, "edge_on");
        add(0, 1, 0, 1, "edge_b_at_fall");
        add(0, 0, 0, 3, "edge_stay_off");
        // 6: reset and B together
        add(1, 1, 0, 1, "rst_b_same");
        add(0, 0, 0, 3, "rst_b_after");
        // B held high: 16 on, 1 off, repeat
        add(0, 1, 1, ONC, "held_on1");
        add(0, 1, 0, 1, "held_gap");
        add(0, 1, 1, ONC, "held_on2");
        add(0, 0, 0, 2, "held_release");

        foreach (vq[i]) step(vq[i].rst, vq[i].b, vq[i].exp_xl, 1'b1, vq[i].name);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 1'b0, 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
